// File: rtl/mem_port_adapter.sv
// CPU multicycle memory port to request/grant/valid physical memory bridge.
// Optional abort-on-timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_port_adapter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err,
    output logic        pmem_req,
    output logic        pmem_we,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_be,
    input  logic        pmem_gnt,
    input  logic        pmem_rvalid,
    input  logic [31:0] pmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic        we_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;
    logic [3:0]  be_reg;
    logic        err_reg, skip_reg;

    logic        accept, complete, abort, stray, err_set;
    logic        timeout_hit, drain_active;

    // Address lanes below word granularity are never forwarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_reg;
    logic          drain_reg;

    assign timeout_hit  = ((state_reg == S_REQ) || (state_reg == S_WAIT)) &&
                          (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
    assign drain_active = drain_reg;

    // drain_reg swallows the late rvalid of an access that was granted but aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            drain_reg <= 1'b0;
        end else begin
            if (accept)
                cnt_reg <= '0;
            else if ((state_reg == S_REQ) || (state_reg == S_WAIT))
                cnt_reg <= cnt_reg + CW'(1);
            if (abort && ((state_reg == S_WAIT) || pmem_gnt))
                drain_reg <= 1'b1;
            else if (pmem_rvalid && drain_reg)
                drain_reg <= 1'b0;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit  = 1'b0;
    assign drain_active = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        complete   = (state_reg == S_WAIT) && pmem_rvalid && !drain_active;
        abort      = timeout_hit && !complete;
        stray      = pmem_rvalid && !drain_active && (state_reg != S_WAIT);
        err_set    = stray || abort;
        case (state_reg)
            S_IDLE: begin
                // skip_reg marks the cycle after RESP, where the CPU request is stale.
                if (!skip_reg && (mem_read || mem_write)) begin
                    accept     = 1'b1;
                    state_next = S_REQ;
                    if (mem_read && mem_write)
                        err_set = 1'b1;
                end
            end
            S_REQ:   if (pmem_gnt) state_next = S_WAIT;
            S_WAIT:  if (complete) state_next = S_RESP;
            default: state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            skip_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            skip_reg  <= (state_reg == S_RESP);
            if (err_set)
                err_reg <= 1'b1;
            if (accept) begin
                we_reg    <= mem_write;
                addr_reg  <= {mem_address[31:2], 2'b00};
                wdata_reg <= mem_wdata;
                be_reg    <= mem_byte_enable;
            end
            if (abort)
                rdata_reg <= '0;
            else if (complete && !we_reg)
                rdata_reg <= pmem_rdata;
        end
    end

    assign pmem_req   = (state_reg == S_REQ);
    assign mem_resp   = (state_reg == S_RESP);
    assign mem_err    = err_reg;
    assign mem_rdata  = rdata_reg;
    assign pmem_we    = we_reg;
    assign pmem_addr  = addr_reg;
    assign pmem_wdata = wdata_reg;
    assign pmem_be    = be_reg;

endmodule

// File: tb/tb_mem_port_adapter.sv
// Directed bench for mem_port_adapter: read, write, back-to-back, both-request,
// reset mid-access and timeout (behaviour depends on MEM_TIMEOUT_EN).
module tb_mem_port_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_address = '0, mem_wdata = '0;
    logic [3:0]  mem_byte_enable = '0;
    logic [31:0] mem_rdata;
    logic        mem_resp, mem_err;
    logic        pmem_req, pmem_we;
    logic [31:0] pmem_addr, pmem_wdata;
    logic [3:0]  pmem_be;
    logic        pmem_gnt = 1'b0, pmem_rvalid = 1'b0;
    logic [31:0] pmem_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int resp_cnt = 0;
    int req_cnt = 0;
    logic req_prev = 1'b0;

    mem_port_adapter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err),
        .pmem_req(pmem_req), .pmem_we(pmem_we), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_be(pmem_be),
        .pmem_gnt(pmem_gnt), .pmem_rvalid(pmem_rvalid), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_resp === 1'b1) resp_cnt++;
        if (pmem_req === 1'b1 && req_prev !== 1'b1) req_cnt++;
        req_prev = pmem_req;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_read = 0; mem_write = 0; pmem_gnt = 0; pmem_rvalid = 0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        tests_run++;
        if ({mem_resp, mem_err, pmem_req, pmem_we} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b exp 0000", {mem_resp, mem_err, pmem_req, pmem_we});
        end
        tests_run++;
        if ({mem_rdata, pmem_addr, pmem_wdata, pmem_be} !== 100'd0) begin
            tests_failed++;
            $display("FAIL reset_data got %h exp 0", {mem_rdata, pmem_addr, pmem_wdata, pmem_be});
        end
        rst_n = 1'b1;
        step();
        $display("[TB] reset done");
    endtask

    task automatic test_read();
        int r0;
        r0 = resp_cnt;
        mem_read = 1; mem_address = 32'h0000_0062;
        tests_run++;
        if (pmem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_c0_req got %b exp 0", pmem_req);
        end
        step(); // cycle 1
        tests_run++;
        if ({pmem_req, pmem_we, pmem_addr} !== {1'b1, 1'b0, 32'h0000_0060}) begin
            tests_failed++;
            $display("FAIL read_c1 got req=%b we=%b addr=%h exp req=1 we=0 addr=00000060", pmem_req, pmem_we, pmem_addr);
        end
        pmem_gnt = 1;
        step(); // cycle 2
        pmem_gnt = 0;
        tests_run++;
        if ({pmem_req, mem_resp} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_c2 got req=%b resp=%b exp 0 0", pmem_req, mem_resp);
        end
        pmem_rvalid = 1; pmem_rdata = 32'hDEAD_BEEF;
        step(); // cycle 3
        pmem_rvalid = 0; pmem_rdata = '0;
        tests_run++;
        if ({mem_resp, mem_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL read_c3 got resp=%b rdata=%h exp 1 deadbeef", mem_resp, mem_rdata);
        end
        step(); // cycle 4
        mem_read = 0;
        tests_run++;
        if ({mem_resp, mem_err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_c4 got resp=%b err=%b exp 0 0", mem_resp, mem_err);
        end
        step();
        tests_run++;
        if (resp_cnt - r0 !== 1) begin
            tests_failed++;
            $display("FAIL read_resp_count got %0d exp 1", resp_cnt - r0);
        end
        $display("[TB] read addr=00000062 rdata=%h", mem_rdata);
    endtask

    task automatic test_write();
        int r0;
        r0 = resp_cnt;
        mem_write = 1; mem_address = 32'h0000_0107; mem_wdata = 32'h1234_5678; mem_byte_enable = 4'b0011;
        step(); // cycle 1
        mem_address = 32'hFFFF_FFFF; mem_wdata = 32'h0; mem_byte_enable = 4'b1100;
        for (int i = 1; i <= 5; i++) begin
            tests_run++;
            if ({pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be} !== {1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'b0011}) begin
                tests_failed++;
                $display("FAIL write_hold_c%0d got req=%b we=%b addr=%h wd=%h be=%b exp 1 1 00000104 12345678 0011",
                         i, pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be);
            end
            if (i < 5) step();
        end
        step(); // cycle 6: grant
        pmem_gnt = 1;
        step();
        pmem_gnt = 0;
        pmem_rvalid = 1; pmem_rdata = 32'hBAD0_BAD0;
        step();
        pmem_rvalid = 0;
        tests_run++;
        if ({mem_resp, mem_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL write_resp got resp=%b rdata=%h exp 1 deadbeef", mem_resp, mem_rdata);
        end
        step();
        mem_write = 0;
        step();
        tests_run++;
        if ({resp_cnt - r0, 31'd0, mem_err} !== {32'd1, 31'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL write_count_err got resp=%0d err=%b exp 1 0", resp_cnt - r0, mem_err);
        end
        $display("[TB] write addr=00000104 wdata=12345678 be=0011");
    endtask

    task automatic test_back_to_back();
        int r0, q0;
        r0 = resp_cnt; q0 = req_cnt;
        mem_read = 1; mem_address = 32'h0000_0200;
        step(); pmem_gnt = 1;                    // c1
        step(); pmem_gnt = 0; pmem_rvalid = 1; pmem_rdata = 32'hCAFE_0001; // c2
        step(); pmem_rvalid = 0;                 // c3 resp, read held
        step();                                  // c4 ignored cycle
        tests_run++;
        if (pmem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_c4_req got %b exp 0", pmem_req);
        end
        mem_address = 32'h0000_0300;
        step();                                  // c5 accepted
        tests_run++;
        if ({pmem_req, req_cnt - q0} !== {1'b0, 32'd1}) begin
            tests_failed++;
            $display("FAIL b2b_c5 got req=%b pulses=%0d exp 0 1", pmem_req, req_cnt - q0);
        end
        step();                                  // c6 second access
        tests_run++;
        if ({pmem_req, pmem_addr} !== {1'b1, 32'h0000_0300}) begin
            tests_failed++;
            $display("FAIL b2b_c6 got req=%b addr=%h exp 1 00000300", pmem_req, pmem_addr);
        end
        pmem_gnt = 1;
        step(); pmem_gnt = 0; pmem_rvalid = 1; pmem_rdata = 32'hCAFE_0002;
        step(); pmem_rvalid = 0; mem_read = 0;
        step(); step();
        tests_run++;
        if ({resp_cnt - r0, req_cnt - q0, mem_rdata} !== {32'd2, 32'd2, 32'hCAFE_0002}) begin
            tests_failed++;
            $display("FAIL b2b_total got resp=%0d req=%0d rdata=%h exp 2 2 cafe0002", resp_cnt - r0, req_cnt - q0, mem_rdata);
        end
        $display("[TB] back-to-back reads 00000200,00000300");
    endtask

    task automatic test_timeout();
        int r0;
        r0 = resp_cnt;
        mem_read = 1; mem_address = 32'h0000_0400;
        step(); // cycle 1: REQ entry
`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i < 9; i++) begin
            if (mem_resp !== 1'b0) begin
                tests_run++; tests_failed++;
                $display("FAIL timeout_early got resp=1 at cycle %0d exp 0", i);
            end
            step();
        end
        tests_run++;
        if ({mem_resp, mem_rdata, mem_err, pmem_req} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_abort got resp=%b rdata=%h err=%b req=%b exp 1 0 1 0", mem_resp, mem_rdata, mem_err, pmem_req);
        end
        mem_read = 0;
        step(); step();
        tests_run++;
        if (resp_cnt - r0 !== 1) begin
            tests_failed++;
            $display("FAIL timeout_resp_count got %0d exp 1", resp_cnt - r0);
        end
`else
        for (int i = 0; i < 20; i++) step();
        tests_run++;
        if ({resp_cnt - r0, 30'd0, pmem_req, mem_err} !== {32'd0, 30'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_none got resp=%0d req=%b err=%b exp 0 1 0", resp_cnt - r0, pmem_req, mem_err);
        end
`endif
        do_reset();
        step();
        $display("[TB] timeout read addr=00000400");
    endtask

    task automatic test_both();
        mem_read = 1; mem_write = 1; mem_address = 32'h0000_0500;
        mem_wdata = 32'hA5A5_A5A5; mem_byte_enable = 4'b1111;
        step(); // c1
        tests_run++;
        if ({pmem_req, pmem_we, mem_err} !== 3'b111) begin
            tests_failed++;
            $display("FAIL both_c1 got req=%b we=%b err=%b exp 1 1 1", pmem_req, pmem_we, mem_err);
        end
        pmem_gnt = 1;
        step(); pmem_gnt = 0; pmem_rvalid = 1; pmem_rdata = 32'h1111_1111;
        step(); pmem_rvalid = 0;
        tests_run++;
        if ({mem_resp, mem_rdata} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL both_resp got resp=%b rdata=%h exp 1 00000000", mem_resp, mem_rdata);
        end
        step(); mem_read = 0; mem_write = 0;
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_err_sticky got %b exp 1", mem_err);
        end
        $display("[TB] read+write addr=00000500 performed as write");
    endtask

    task automatic test_reset_mid();
        int r0;
        do_reset();
        step();
        r0 = resp_cnt;
        mem_read = 1; mem_address = 32'h0000_0600;
        step(); pmem_gnt = 1;
        step(); pmem_gnt = 0;                   // c2: WAIT
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({pmem_req, mem_resp, mem_err, pmem_addr} !== {3'b000, 32'h0}) begin
            tests_failed++;
            $display("FAIL midreset_async got req=%b resp=%b err=%b addr=%h exp 0 0 0 0", pmem_req, mem_resp, mem_err, pmem_addr);
        end
        mem_read = 0;
        step();
        rst_n = 1'b1;
        step();
        pmem_rvalid = 1; pmem_rdata = 32'h7777_7777;
        step();
        pmem_rvalid = 0;
        step(); step();
        tests_run++;
        if ({resp_cnt - r0, 31'd0, mem_err} !== {32'd0, 31'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL midreset_stray got resp=%0d err=%b exp 0 1", resp_cnt - r0, mem_err);
        end
        $display("[TB] reset during read addr=00000600, stray rvalid");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_both();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
